// File: rtl/inst_mem_ctrl.sv
// Instruction-fetch responder for an external asynchronous SRAM, with a boot-time load port.
// One FSM arbitrates fetch/load, sequences the strobes for WAIT+1 cycles and pulses ready/ack.
module inst_mem_ctrl #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instEnable_i,
  input  logic [15:0]       instAddr_i,
  output logic [DATA_W-1:0] instData_o,
  output logic              instReady_o,
  input  logic              loadEnable_i,
  input  logic [15:0]       loadAddr_i,
  input  logic [DATA_W-1:0] loadData_i,
  output logic              loadAck_o,
  output logic [ADDR_W-1:0] sramAddr_o,
  input  logic [DATA_W-1:0] sramDataIn_i,
  output logic [DATA_W-1:0] sramDataOut_o,
  output logic              sramDataOe_o,
  output logic              sramCe_n_o,
  output logic              sramOe_n_o,
  output logic              sramWe_n_o
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StRecover} state_e;

  localparam logic [2:0] WaitCnt = 3'(WAIT);

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic [DATA_W-1:0]   inst_data_q;
  logic                inst_ready_q;
  logic                load_ack_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_dout_q;
  logic                sram_doe_q;
  logic                sram_ce_n_q;
  logic                sram_oe_n_q;
  logic                sram_we_n_q;

  // Strobes are set on the edge entering a state so they are valid for the whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      inst_data_q  <= '0;
      inst_ready_q <= 1'b0;
      load_ack_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_dout_q  <= '0;
      sram_doe_q   <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
    end else begin
      inst_ready_q <= 1'b0;
      load_ack_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= 3'd0;
          if (loadEnable_i) begin
            sram_addr_q <= ADDR_W'(loadAddr_i);
            sram_dout_q <= loadData_i;
            sram_ce_n_q <= 1'b0;
            sram_we_n_q <= 1'b0;
            sram_oe_n_q <= 1'b1;
            sram_doe_q  <= 1'b1;
            state_q     <= StWrite;
          end else if (instEnable_i) begin
            sram_addr_q <= ADDR_W'(instAddr_i);
            sram_ce_n_q <= 1'b0;
            sram_oe_n_q <= 1'b0;
            sram_we_n_q <= 1'b1;
            sram_doe_q  <= 1'b0;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (cnt_q == WaitCnt) begin
            inst_data_q  <= sramDataIn_i;
            inst_ready_q <= 1'b1;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            cnt_q        <= 3'd0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StWrite: begin
          if (cnt_q == WaitCnt) begin
            // Release WE first; CE and the data bus stay asserted for hold time.
            sram_we_n_q <= 1'b1;
            cnt_q       <= 3'd0;
            state_q     <= StRecover;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StRecover: begin
          load_ack_q  <= 1'b1;
          sram_ce_n_q <= 1'b1;
          sram_doe_q  <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instData_o    = inst_data_q;
  assign instReady_o   = inst_ready_q;
  assign loadAck_o     = load_ack_q;
  assign sramAddr_o    = sram_addr_q;
  assign sramDataOut_o = sram_dout_q;
  assign sramDataOe_o  = sram_doe_q;
  assign sramCe_n_o    = sram_ce_n_q;
  assign sramOe_n_o    = sram_oe_n_q;
  assign sramWe_n_o    = sram_we_n_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl: three instances (WAIT = 0, 1, 2), each with its own SRAM
// model; fetch results are checked against a scoreboard queue filled when requests are driven.
module tb_inst_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic        load_en;
  logic [15:0] inst_addr;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  int          sel;

  logic        ie     [3];
  logic        le     [3];
  logic [15:0] idata  [3];
  logic        irdy   [3];
  logic        lack   [3];
  logic [17:0] saddr  [3];
  logic [15:0] sdin   [3];
  logic [15:0] sdout  [3];
  logic        sdoe   [3];
  logic        ce_n   [3];
  logic        oe_n   [3];
  logic        we_n   [3];

  logic [15:0] exp_mem [256];
  logic [15:0] q [$];
  int          n_pass;
  int          n_total;

  function automatic logic [15:0] pat(input int i);
    return {8'hC3 ^ 8'(i), 8'(i)};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance index equals its WAIT value, so sel selects both DUT and wait count.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] mem [256];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = pat(i);
      mem[4] = 16'h4E01;
    end

    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g] && sdoe[g]) mem[saddr[g][7:0]] <= sdout[g];
    end

    assign sdin[g] = (!ce_n[g] && !oe_n[g]) ? mem[saddr[g][7:0]] : 16'hDEAD;
    assign ie[g]   = (sel == g) && inst_en;
    assign le[g]   = (sel == g) && load_en;

    inst_mem_ctrl #(
      .ADDR_W(18),
      .DATA_W(16),
      .WAIT  (g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .instEnable_i (ie[g]),
      .instAddr_i   (inst_addr),
      .instData_o   (idata[g]),
      .instReady_o  (irdy[g]),
      .loadEnable_i (le[g]),
      .loadAddr_i   (load_addr),
      .loadData_i   (load_data),
      .loadAck_o    (lack[g]),
      .sramAddr_o   (saddr[g]),
      .sramDataIn_i (sdin[g]),
      .sramDataOut_o(sdout[g]),
      .sramDataOe_o (sdoe[g]),
      .sramCe_n_o   (ce_n[g]),
      .sramOe_n_o   (oe_n[g]),
      .sramWe_n_o   (we_n[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every ready pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (irdy[sel] || lack[sel]) check("ready_ack_exclusive", 32'(irdy[sel] & lack[sel]), 32'd0);
    if (irdy[sel]) begin
      check("ready_has_pending_fetch", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("fetch_data", 32'(idata[sel]), 32'(q.pop_front()));
    end
  end

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    inst_en   = 1'b0;
    load_en   = 1'b0;
    inst_addr = '0;
    load_addr = '0;
    load_data = '0;
    sel       = 1;
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
    exp_mem[4] = 16'h4E01;

    // Reset values
    cyc(3);
    check("rst_ce_n", 32'(ce_n[sel]), 32'd1);
    check("rst_oe_n", 32'(oe_n[sel]), 32'd1);
    check("rst_we_n", 32'(we_n[sel]), 32'd1);
    check("rst_doe", 32'(sdoe[sel]), 32'd0);
    check("rst_ready", 32'(irdy[sel]), 32'd0);
    check("rst_ack", 32'(lack[sel]), 32'd0);
    check("rst_data", 32'(idata[sel]), 32'd0);
    check("rst_addr", 32'(saddr[sel]), 32'd0);
    check("rst_dout", 32'(sdout[sel]), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Single fetch, WAIT=1
    inst_en   = 1'b1;
    inst_addr = 16'h0004;
    q.push_back(exp_mem[4]);
    cyc(1);
    check("f1_c1_ce_n", 32'(ce_n[sel]), 32'd0);
    check("f1_c1_oe_n", 32'(oe_n[sel]), 32'd0);
    check("f1_c1_we_n", 32'(we_n[sel]), 32'd1);
    check("f1_c1_doe", 32'(sdoe[sel]), 32'd0);
    check("f1_c1_addr", 32'(saddr[sel]), 32'h4);
    inst_en = 1'b0;
    cyc(1);
    check("f1_c2_ce_n", 32'(ce_n[sel]), 32'd0);
    check("f1_c2_oe_n", 32'(oe_n[sel]), 32'd0);
    check("f1_c2_ready", 32'(irdy[sel]), 32'd0);
    cyc(1);
    check("f1_c3_ready", 32'(irdy[sel]), 32'd1);
    check("f1_c3_data", 32'(idata[sel]), 32'h4E01);
    check("f1_c3_ce_n", 32'(ce_n[sel]), 32'd1);
    cyc(1);
    check("f1_c4_ready", 32'(irdy[sel]), 32'd0);
    cyc(3);
    check("f1_data_held", 32'(idata[sel]), 32'h4E01);
    check("f1_drained", 32'(q.size()), 32'd0);

    // Reset for two cycles in the middle of a READ
    inst_en   = 1'b1;
    inst_addr = 16'h0004;
    cyc(1);
    check("rr_in_read_ce_n", 32'(ce_n[sel]), 32'd0);
    rst     = 1'b1;
    inst_en = 1'b0;
    cyc(1);
    check("rr_ce_n", 32'(ce_n[sel]), 32'd1);
    check("rr_oe_n", 32'(oe_n[sel]), 32'd1);
    check("rr_ready", 32'(irdy[sel]), 32'd0);
    check("rr_data", 32'(idata[sel]), 32'd0);
    check("rr_addr", 32'(saddr[sel]), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(6);
    check("rr_idle_ce_n", 32'(ce_n[sel]), 32'd1);
    check("rr_data_after", 32'(idata[sel]), 32'd0);

    // Load 0xABCD to 0x0010 with WAIT=2, then fetch it back
    sel       = 2;
    load_en   = 1'b1;
    load_addr = 16'h0010;
    load_data = 16'hABCD;
    exp_mem[16] = 16'hABCD;
    for (int c = 1; c <= 6; c++) begin
      cyc(1);
      if (c == 1) begin
        load_en = 1'b0;
        check("ld_dout", 32'(sdout[sel]), 32'hABCD);
        check("ld_addr", 32'(saddr[sel]), 32'h10);
      end
      check($sformatf("ld_c%0d_we_n", c), 32'(we_n[sel]), (c <= 3) ? 32'd0 : 32'd1);
      check($sformatf("ld_c%0d_doe", c), 32'(sdoe[sel]), (c <= 4) ? 32'd1 : 32'd0);
      check($sformatf("ld_c%0d_ce_n", c), 32'(ce_n[sel]), (c <= 4) ? 32'd0 : 32'd1);
      check($sformatf("ld_c%0d_ack", c), 32'(lack[sel]), (c == 5) ? 32'd1 : 32'd0);
    end
    inst_en   = 1'b1;
    inst_addr = 16'h0010;
    q.push_back(exp_mem[16]);
    cyc(1);
    inst_en = 1'b0;
    cyc(5);
    check("ld_readback_drained", 32'(q.size()), 32'd0);

    // Simultaneous load and fetch: load wins, fetch accepted in the ack cycle
    load_en   = 1'b1;
    load_addr = 16'h0001;
    load_data = 16'h1234;
    exp_mem[1] = 16'h1234;
    inst_en   = 1'b1;
    inst_addr = 16'h0002;
    q.push_back(exp_mem[2]);
    for (int c = 1; c <= 10; c++) begin
      cyc(1);
      if (c == 1) begin
        check("sim_load_first_we_n", 32'(we_n[sel]), 32'd0);
        load_en = 1'b0;
      end
      check($sformatf("sim_c%0d_ack", c), 32'(lack[sel]), (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("sim_c%0d_ready", c), 32'(irdy[sel]), (c == 9) ? 32'd1 : 32'd0);
      if (c == 6) begin
        check("sim_fetch_oe_n", 32'(oe_n[sel]), 32'd0);
        check("sim_fetch_addr", 32'(saddr[sel]), 32'h2);
        inst_en = 1'b0;
      end
    end
    check("sim_drained", 32'(q.size()), 32'd0);

    // Back-to-back fetches with WAIT=0, address advanced every access
    sel = 0;
    cyc(1);
    inst_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      inst_addr = 16'h0020 + 16'(k);
      q.push_back(exp_mem[32 + k]);
      cyc(1);
      check($sformatf("b2b_%0d_read_ready", k), 32'(irdy[sel]), 32'd0);
      check($sformatf("b2b_%0d_oe_n", k), 32'(oe_n[sel]), 32'd0);
      check($sformatf("b2b_%0d_addr", k), 32'(saddr[sel]), 32'h20 + 32'(k));
      cyc(1);
      check($sformatf("b2b_%0d_ready", k), 32'(irdy[sel]), 32'd1);
    end
    inst_en = 1'b0;
    cyc(3);
    check("b2b_drained", 32'(q.size()), 32'd0);
    check("b2b_idle_ce_n", 32'(ce_n[sel]), 32'd1);

    // Fetch request dropped in the first READ cycle still completes once
    sel       = 1;
    inst_en   = 1'b1;
    inst_addr = 16'h0030;
    q.push_back(exp_mem[48]);
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (c == 1) inst_en = 1'b0;
      check($sformatf("drop_c%0d_ready", c), 32'(irdy[sel]), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("drop_c%0d_ce_n", c), 32'(ce_n[sel]), (c <= 2) ? 32'd0 : 32'd1);
    end
    check("drop_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Responder side of the CPU instruction-fetch port: accepts fetch requests (address plus enable) from the CPU and returns instruction words read from the board's external asynchronous SRAM, which needs multi-cycle accesses. Also provides a program-load write port used by the boot loader to fill SRAM before the CPU runs. A single FSM arbitrates the two requesters, sequences the SRAM strobes with a programmable wait count and returns a one-cycle completion pulse per access.

## Interface
- ADDR_W, 18, SRAM address width; request addresses are zero-extended to it
- DATA_W, 16, instruction/SRAM data width
- WAIT, 1, extra SRAM access cycles, legal range 0..7

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- instEnable_i  in  1  fetch request (level)
- instAddr_i  in  16  fetch word address
- instData_o  out  DATA_W  last fetched instruction, held until next fetch completes
- instReady_o  out  1  one-cycle pulse: instData_o valid for the accepted fetch
- loadEnable_i  in  1  program-load write request (level)
- loadAddr_i  in  16  load word address
- loadData_i  in  DATA_W  load data
- loadAck_o  out  1  one-cycle pulse: write complete
- sramAddr_o  out  ADDR_W  SRAM address
- sramDataIn_i  in  DATA_W  SRAM read data
- sramDataOut_o  out  DATA_W  SRAM write data
- sramDataOe_o  out  1  1 = drive SRAM data bus (external tristate)
- sramCe_n_o, sramOe_n_o, sramWe_n_o  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, READ, WRITE, RECOVER. 3-bit wait counter cnt. All outputs registered.
- IDLE: if loadEnable_i → latch loadAddr_i/loadData_i, go WRITE; else if instEnable_i → latch instAddr_i, go READ; else stay. Load has priority when both asserted.
- READ: sramCe_n_o=0, sramOe_n_o=0, sramWe_n_o=1, sramDataOe_o=0, address held. Lasts WAIT+1 cycles (cnt 0..WAIT). On the last cycle's edge: instData_o ← sramDataIn_i, instReady_o ← 1, go IDLE.
- WRITE: sramCe_n_o=0, sramWe_n_o=0, sramOe_n_o=1, sramDataOe_o=1, address/data held. Lasts WAIT+1 cycles, then RECOVER.
- RECOVER: one cycle, sramWe_n_o=1, sramCe_n_o=0, data still driven (hold time); on exit loadAck_o ← 1, go IDLE.
- IDLE drives all strobes high, sramDataOe_o=0; sramAddr_o/sramDataOut_o keep last value.
- Requests are sampled only in IDLE. Deasserting a request mid-access does not abort: the access completes and still pulses ready/ack.
- A request still high in the IDLE cycle where ready/ack pulses is a new request and is accepted that cycle (back-to-back).
- Starvation of fetch by a continuously held loadEnable_i is accepted; the loader drops loadEnable_i after each ack.
- Address mapping: sramAddr_o = {(ADDR_W-16) zeros, addr}.

## Timing
- Reset values: state IDLE, cnt 0, instData_o 0, instReady_o 0, loadAck_o 0, sramAddr_o 0, sramDataOut_o 0, sramDataOe_o 0, all strobes 1.
- Fetch, request seen in IDLE cycle 0: strobes low in cycles 1..1+WAIT; instReady_o high and new instData_o in cycle 2+WAIT. Throughput 1 fetch per WAIT+2 cycles.
- Load, request seen in cycle 0: sramWe_n_o low in cycles 1..1+WAIT; RECOVER in cycle 2+WAIT; loadAck_o high in cycle 3+WAIT.
- instReady_o and loadAck_o are never high in the same cycle and are high at most one cycle per access.
- rst high mid-access: on the next edge all outputs take reset values, with no ready/ack pulse for the aborted access. instData_o clears to 0.
- WAIT=0: READ and WRITE each last exactly one cycle.

## Test plan
- Reset: rst held 2 cycles mid-READ → strobes 1, instReady_o 0, instData_o 0; no pulse after release with requests low.
- Single fetch, WAIT=1, instAddr_i=0x0004, SRAM model returns 0x4E01 → Ce/Oe low cycles 1–2, instReady_o pulse cycle 3, instData_o=0x4E01 held afterward.
- Load then read back, WAIT=2: write 0xABCD to 0x0010 → We_n low 3 cycles, sramDataOe_o high 4 cycles, loadAck_o cycle 5; fetching 0x0010 then returns 0xABCD.
- Simultaneous requests in IDLE (load 0x0001/0x1234, fetch 0x0002) → write first, ack; fetch accepted in the ack cycle; instReady_o at ack+WAIT+2.
- Continuous instEnable_i with incrementing address, WAIT=0 → one instReady_o every 2 cycles, data matching each sampled address.
- instEnable_i dropped in first READ cycle → access completes, instReady_o still pulses once, then IDLE with no further access.
